// File: rtl/cp0_timer_irq_pkg.sv
// Shared types and constants for the CP0 Count/Compare timer and interrupt backend.
package cp0_timer_irq_pkg;

  typedef enum logic [1:0] {
    WSEL_COUNT   = 2'd0,
    WSEL_COMPARE = 2'd1,
    WSEL_CAUSE   = 2'd2,
    WSEL_NONE    = 2'd3
  } cp0_wsel_t;

  localparam int CAUSE_IP_SW_LO = 8;
  localparam int TIMER_IP_BIT   = 7;

endpackage

// File: rtl/cp0_timer_irq_int_sync.sv
// Per-bit flop synchronizer of configurable depth for asynchronous interrupt lines.
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_timer_irq.sv
// CP0 backend: Count/Compare timer with divider, Cause.TI/IP, and registered interrupt request.
module cp0_timer_irq
  import cp0_timer_irq_pkg::*;
#(
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        status_erl,
  input  logic [7:0]  status_im,
  input  logic [5:0]  hw_int,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        cause_ti,
  output logic [7:0]  cause_ip,
  output logic        int_req
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic [1:0]    ip_sw_q, ip_sw_d;
  logic          int_req_q, int_req_d;
  logic [5:0]    hw_sync;

  cp0_wsel_t wsel;
  logic      tick;
  logic      wr_count, wr_compare, wr_cause;

  int_sync #(
    .WIDTH (6),
    .STAGES(SYNC_STAGES)
  ) u_int_sync (
    .clk_i (clk),
    .rst_ni(resetn),
    .d_i   (hw_int),
    .q_o   (hw_sync)
  );

  assign wsel       = cp0_wsel_t'(wr_sel);
  assign wr_count   = wr_en && (wsel == WSEL_COUNT);
  assign wr_compare = wr_en && (wsel == WSEL_COMPARE);
  assign wr_cause   = wr_en && (wsel == WSEL_CAUSE);
  assign tick       = (phase_q == PHASE_LAST);

  always_comb begin
    phase_d   = phase_q + PW'(1);
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    ip_sw_d   = ip_sw_q;

    if (wr_count || tick) begin
      phase_d = '0;
    end

    // A software Count write overrides the increment that the same tick would have done.
    if (wr_count) begin
      count_d = wr_data;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end

    if (wr_compare) begin
      compare_d = wr_data;
    end

    // Match is only recognised on an increment, and a Compare write always clears TI.
    if (wr_compare) begin
      ti_d = 1'b0;
    end else if (tick && !wr_count && ((count_q + 32'd1) == compare_q)) begin
      ti_d = 1'b1;
    end

    if (wr_cause) begin
      ip_sw_d = wr_data[CAUSE_IP_SW_LO +: 2];
    end
  end

  always_comb begin
    cause_ip               = {hw_sync, ip_sw_q};
    cause_ip[TIMER_IP_BIT] = hw_sync[5] | ti_q;
  end

  assign int_req_d = (|(cause_ip & status_im)) & status_ie & ~status_exl & ~status_erl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
      ip_sw_q   <= '0;
      int_req_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      ip_sw_q   <= ip_sw_d;
      int_req_q <= int_req_d;
    end
  end

  assign count    = count_q;
  assign compare  = compare_q;
  assign cause_ti = ti_q;
  assign int_req  = int_req_q;

endmodule
